// File: rtl/qlearn_pkg.sv
// Shared Q-learning datapath definitions: sizes, scan FSM states and a
// signed/unsigned greater-than helper.
package qlearn_pkg;

    localparam int DATA_W = 16;
    localparam int N_ACT  = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    function automatic logic q_gt(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b,
                                  input logic              signed_cmp);
        logic res;
        if (signed_cmp) begin
            res = ($signed(a) > $signed(b));
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

endpackage

// File: rtl/qmax_cmp.sv
// Combinational strict greater-than comparator, shared by the max and min
// scan stages.
module qmax_cmp #(
    parameter int DATA_W     = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b
);

    generate
        if (SIGNED_CMP) begin : g_signed
            assign a_gt_b = ($signed(a) > $signed(b));
        end else begin : g_unsigned
            assign a_gt_b = (a > b);
        end
    endgenerate

endmodule

// File: rtl/qmax_scanner.sv
// Sequential argmax over the Q-value mux: sweeps sel_o one entry per clock
// and keeps the running maximum and its index.
module qmax_scanner #(
    parameter int DATA_W     = qlearn_pkg::DATA_W,
    parameter int N_ACT      = qlearn_pkg::N_ACT,
    parameter int SEL_W      = qlearn_pkg::SEL_W,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [SEL_W:0]    num_act_i,
    output logic [SEL_W-1:0]  sel_o,
    input  logic [DATA_W-1:0] mux_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] max_val_o,
    output logic [SEL_W-1:0]  max_idx_o
);

    import qlearn_pkg::*;

    localparam logic [SEL_W:0] N_ACT_W = (SEL_W+1)'(N_ACT);

    scan_state_e       state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W:0]    lim_q;
    logic [SEL_W:0]    lim_d;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] max_val_q;
    logic [SEL_W-1:0]  max_idx_q;
    logic              gt_s;
    logic              take_s;
    logic              last_s;

    qmax_cmp #(
        .DATA_W    (DATA_W),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_cmp (
        .a     (mux_dout_i),
        .b     (max_val_q),
        .a_gt_b(gt_s)
    );

    // Clamp the requested length; entry 0 always seeds the running maximum.
    always_comb begin
        lim_d = num_act_i;
        if ((num_act_i == (SEL_W+1)'(0)) || (num_act_i > N_ACT_W)) begin
            lim_d = N_ACT_W;
        end else begin
            lim_d = num_act_i;
        end
        take_s = (sel_q == SEL_W'(0)) || gt_s;
        last_s = ({1'b0, sel_q} == (lim_q - (SEL_W+1)'(1)));
    end

    // Scan FSM with select counter and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_W'(0);
            lim_q     <= (SEL_W+1)'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_val_q <= DATA_W'(0);
            max_idx_q <= SEL_W'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        lim_q   <= lim_d;
                        sel_q   <= SEL_W'(0);
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (take_s) begin
                        max_val_q <= mux_dout_i;
                        max_idx_q <= sel_q;
                    end
                    if (last_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign max_val_o = max_val_q;
    assign max_idx_o = max_idx_q;

endmodule

// File: doc/qmax_scanner.md
Name: qmax_scanner

Overview:
- Sequential argmax stage placed directly downstream of the 16:1 Q-value multiplexer (Mux16to1) in the Q-learning datapath.
- Owns the mux select, sweeps the action entries one per clock, and compares each returned word against a running maximum.
- Reports the maximum Q-value and its action index to the policy/update logic through a start/busy/done handshake.

Parameters:
- DATA_W, 16, width of the Q-value word returned by the mux.
- N_ACT, 16, number of mux inputs (actions); a power of two, at most 2**SEL_W.
- SEL_W, 4, mux select width; equals clog2(N_ACT).
- SIGNED_CMP, 0, 0 selects unsigned comparison; 1 selects two's-complement comparison.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- num_act_i  in  SEL_W+1  number of entries to scan, 1..N_ACT; 0 or any value above N_ACT is treated as N_ACT; latched on accepted start.
- sel_o  out  SEL_W  select to the mux; registered.
- mux_dout_i  in  DATA_W  mux output for the current sel_o; combinational path, same cycle.
- busy_o  out  1  high from the cycle after an accepted start through the last SCAN cycle.
- done_o  out  1  one-cycle pulse when the result is valid.
- max_val_o  out  DATA_W  maximum value found; held until the next accepted start.
- max_idx_o  out  SEL_W  index of the maximum; held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; sel_o, busy_o, done_o, max_val_o, max_idx_o, internal count and limit all 0. An assertion mid-scan aborts immediately, with no done pulse.
- Clock and reset use only these two ports; no other clock or reset exists.
- States: IDLE, SCAN, DONE.
- IDLE: when start_i=1, latch limit L=num_act_i (clamped as above), set sel_o=0 and busy_o=1, go to SCAN. When start_i=0, stay in IDLE and hold outputs.
- SCAN, on each cycle with sel_o=k:
  - Sample mux_dout_i as entry k.
  - If k==0, or entry k is strictly greater than max_val_o, update max_val_o=entry and max_idx_o=k.
  - On a tie the earlier (lower) index is kept.
  - If k==L-1, go to DONE and clear busy_o. Otherwise increment sel_o.
- DONE: assert done_o for exactly one cycle, return to IDLE, and leave sel_o at its last value.
- Latency: start accepted at edge 0. SCAN occupies L cycles. done_o is high during cycle L+1. For L=16, done_o is high in cycle 17.
- During the SCAN cycle for entry 0, max_val_o and max_idx_o change. Downstream reads them only when done_o=1.
- start_i while in SCAN or DONE is ignored, not queued. start_i in the same cycle done_o is high is also ignored, because the FSM is not yet back in IDLE.
- Comparison uses the full DATA_W width, signed or unsigned according to SIGNED_CMP. No arithmetic beyond compare; there is no overflow case.
- The sel_o counter never wraps, because L is at most N_ACT. An L of 1 gives a single SCAN cycle with result entry 0.
- mux_dout_i must settle within one cycle of a sel_o change. The mux is combinational, so no pipeline stage is inserted.

Decomposition:
- Shared package qlearn_pkg holds DATA_W, N_ACT, SEL_W, the FSM state enum (IDLE/SCAN/DONE), and a signed/unsigned greater-than function.
- One sub-module, qmax_cmp: a combinational comparator with SIGNED_CMP, DATA_W, inputs a and b, output a_gt_b. It is shared with the future min-scan stage.
- FSM, counter and result registers live in qmax_scanner.

Test Plan:
- Ascending: d_k=k for all 16 entries, num_act=16, start pulse → sel_o steps 0..15 on consecutive cycles; done_o in cycle 17; max_val_o=15, max_idx_o=15; busy_o high for exactly 16 cycles.
- Descending, plus ties: d_k=15-k → max_val_o=15, max_idx_o=0. All d_k=7 → max_val_o=7, max_idx_o=0.
- Partial scan: d_k=k, num_act=5 → sel_o reaches only 4; done_o in cycle 6; result 4 at index 4. With num_act=0 → full 16-entry scan, result 15 at index 15.
- Signed mode: SIGNED_CMP=1, d3=16'hFFFF, d9=16'h0003, all others 0 → max_val_o=3, max_idx_o=9. With SIGNED_CMP=0 → max_val_o=16'hFFFF, max_idx_o=3.
- Handshake: start_i re-asserted in SCAN cycle 4 and in the done_o cycle → no restart and exactly one done_o. A start one cycle after done_o → new scan begins and the previous result is held until entry 0 is sampled.
- Reset mid-scan: rst_n low during the SCAN cycle with sel_o=8 → all outputs 0 immediately and no done_o. After release, a new start gives a correct full scan.
